// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types, widths and width helpers for the PLL reset sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_e;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The shared counter must hold the largest of the three cycle limits.
    function automatic int cnt_width(input int a, input int b, input int c);
        return $clog2(max3(a, b, c)) + 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop single-bit synchronizer, async reset to 0
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset, lock-wait with retries, and core reset release sequencer
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD    = 64,
    parameter int LOCK_TMO    = 50000,
    parameter int STABLE_CYC  = 1024,
    parameter int MAX_RETRY   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_rst,
    output logic               core_rst,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  loss_cnt,
    output logic [2:0]         state_o
);

    localparam int CNT_W = cnt_width(RST_HOLD, LOCK_TMO, STABLE_CYC);
    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST    = CNT_W'(LOCK_TMO - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

    logic [1:0] rst_sync_q;
    logic       rst_int;
    logic       lk;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [LOSS_W-1:0]  loss_q, loss_d, loss_inc;
    logic               pll_rst_q, core_rst_q, ready_q, fail_q;

    // Assert asynchronously, release two refclk edges after rst drops.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst_int),
        .d_i   (pll_locked),
        .q_o   (lk)
    );

    assign loss_inc = (&loss_q) ? loss_q : loss_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (restart) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
            if (state_q == RUN && !lk) begin
                loss_d = loss_inc;
            end
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lk) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TMO_LAST) begin
                        retry_d = retry_q + 1'b1;
                        cnt_d   = '0;
                        state_d = (retry_d == RETRY_MAX) ? FAIL : PLL_RST;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE: begin
                    // Any dropout re-arms the lock timeout without charging a retry.
                    if (!lk) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state_d = PLL_RST;
                        cnt_d   = '0;
                        retry_d = '0;
                        loss_d  = loss_inc;
                    end
                end
                FAIL: begin
                end
                default: begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or posedge rst_int) begin
        if (rst_int) begin
            state_q    <= PLL_RST;
            cnt_q      <= '0;
            retry_q    <= '0;
            loss_q     <= '0;
            pll_rst_q  <= 1'b1;
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            loss_q     <= loss_d;
            pll_rst_q  <= (state_d == PLL_RST) || (state_d == FAIL);
            core_rst_q <= (state_d != RUN);
            ready_q    <= (state_d == RUN);
            fail_q     <= (state_d == FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign core_rst  = core_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed vector bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    typedef struct {
        string      name;
        logic       locked;
        logic       restart;
        int         ticks;
        logic       pll_rst;
        logic       core_rst;
        logic       ready;
        logic       fail;
        logic [3:0] retry;
        logic [7:0] loss;
        logic [2:0] state;
    } vec_t;

    localparam logic [2:0] S_RST = 3'd0, S_WAIT = 3'd1, S_STAB = 3'd2, S_RUN = 3'd3, S_FAIL = 3'd4;

    logic       refclk, rst, pll_locked, restart;
    logic       pll_rst, core_rst, ready, fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    vec_t tbl[$];

    pll_reset_sequencer #(
        .RST_HOLD(4), .LOCK_TMO(20), .STABLE_CYC(8), .MAX_RETRY(3), .SYNC_STAGES(2)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .core_rst   (core_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt),
        .state_o    (state_o)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick();
        @(negedge refclk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic lk, input logic rs, input int t,
                                input logic pr, input logic cr, input logic rd, input logic fl,
                                input logic [3:0] rc, input logic [7:0] lc, input logic [2:0] st);
        vec_t v;
        v.name = n; v.locked = lk; v.restart = rs; v.ticks = t;
        v.pll_rst = pr; v.core_rst = cr; v.ready = rd; v.fail = fl;
        v.retry = rc; v.loss = lc; v.state = st;
        return v;
    endfunction

    task automatic chk_row(input vec_t v);
        chk({v.name, ".pll_rst"},  pll_rst,   v.pll_rst);
        chk({v.name, ".core_rst"}, core_rst,  v.core_rst);
        chk({v.name, ".ready"},    ready,     v.ready);
        chk({v.name, ".fail"},     fail,      v.fail);
        chk({v.name, ".retry"},    retry_cnt, v.retry);
        chk({v.name, ".loss"},     loss_cnt,  v.loss);
        chk({v.name, ".state"},    state_o,   v.state);
    endtask

    task automatic count_pll_rst(input logic val, input int bound, output int n);
        n = 0;
        while (pll_rst === val && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ready(input string name, output logic ok);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        ok = (ready === 1'b1);
        chk(name, ready, 1'b1);
    endtask

    initial begin
        int   n;
        logic ok;

        // Lock, loss, restart and STABLE-glitch timeline from the first reset release.
        tbl.push_back(mk("hold",        0, 0,  5, 1, 1, 0, 0, 0, 0, S_RST));
        tbl.push_back(mk("hold_end",    0, 0,  1, 0, 1, 0, 0, 0, 0, S_WAIT));
        tbl.push_back(mk("wait",        0, 0,  9, 0, 1, 0, 0, 0, 0, S_WAIT));
        tbl.push_back(mk("stable",      1, 0, 10, 0, 1, 0, 0, 0, 0, S_STAB));
        tbl.push_back(mk("run",         1, 0,  1, 0, 0, 1, 0, 0, 0, S_RUN));
        tbl.push_back(mk("drop",        0, 0,  1, 0, 0, 1, 0, 0, 0, S_RUN));
        tbl.push_back(mk("drop_sync",   1, 0,  1, 0, 0, 1, 0, 0, 0, S_RUN));
        tbl.push_back(mk("loss",        1, 0,  1, 1, 1, 0, 0, 0, 1, S_RST));
        tbl.push_back(mk("loss_hold",   1, 0,  3, 1, 1, 0, 0, 0, 1, S_RST));
        tbl.push_back(mk("loss_wait",   1, 0,  1, 0, 1, 0, 0, 0, 1, S_WAIT));
        tbl.push_back(mk("relock",      1, 0,  1, 0, 1, 0, 0, 0, 1, S_STAB));
        tbl.push_back(mk("relock_stab", 1, 0,  7, 0, 1, 0, 0, 0, 1, S_STAB));
        tbl.push_back(mk("rerun",       1, 0,  1, 0, 0, 1, 0, 0, 1, S_RUN));
        tbl.push_back(mk("restart",     1, 1,  1, 1, 1, 0, 0, 0, 1, S_RST));
        tbl.push_back(mk("rs_wait",     1, 0,  4, 0, 1, 0, 0, 0, 1, S_WAIT));
        tbl.push_back(mk("rs_stab",     1, 0,  1, 0, 1, 0, 0, 0, 1, S_STAB));
        tbl.push_back(mk("good5",       1, 0,  4, 0, 1, 0, 0, 0, 1, S_STAB));
        tbl.push_back(mk("glitch",      0, 0,  1, 0, 1, 0, 0, 0, 1, S_STAB));
        tbl.push_back(mk("glitch_sync", 1, 0,  1, 0, 1, 0, 0, 0, 1, S_STAB));
        tbl.push_back(mk("glitch_back", 1, 0,  1, 0, 1, 0, 0, 0, 1, S_WAIT));
        tbl.push_back(mk("glitch_lock", 1, 0,  1, 0, 1, 0, 0, 0, 1, S_STAB));
        tbl.push_back(mk("clean7",      1, 0,  7, 0, 1, 0, 0, 0, 1, S_STAB));
        tbl.push_back(mk("clean8",      1, 0,  1, 0, 0, 1, 0, 0, 1, S_RUN));

        rst = 1'b1; pll_locked = 1'b0; restart = 1'b0;
        tick(); tick();
        chk_row(mk("reset", 0, 0, 0, 1, 1, 0, 0, 0, 0, S_RST));

        rst = 1'b0;
        foreach (tbl[i]) begin
            pll_locked = tbl[i].locked;
            restart    = tbl[i].restart;
            for (int t = 0; t < tbl[i].ticks; t++) tick();
            chk_row(tbl[i]);
        end
        restart = 1'b0;

        // Three lock timeouts into FAIL.
        pll_locked = 1'b0; restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("tmo.start_state", state_o, S_RST);
        for (int k = 0; k < 3; k++) begin
            count_pll_rst(1'b1, 40, n);
            chk($sformatf("tmo%0d.rst_pulse", k), n, 4);
            count_pll_rst(1'b0, 40, n);
            chk($sformatf("tmo%0d.wait_len", k), n, 20);
            chk($sformatf("tmo%0d.retry", k), retry_cnt, k + 1);
        end
        chk_row(mk("fail", 0, 0, 0, 1, 1, 0, 1, 3, 1, S_FAIL));
        for (int t = 0; t < 30; t++) tick();
        chk_row(mk("fail_hold", 0, 0, 0, 1, 1, 0, 1, 3, 1, S_FAIL));
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk_row(mk("fail_restart", 0, 0, 0, 1, 1, 0, 0, 0, 1, S_RST));

        // Asynchronous reset in WAIT_LOCK and in RUN.
        for (int t = 0; t < 4; t++) tick();
        chk("pre_rst.state", state_o, S_WAIT);
        rst = 1'b1;
        #1;
        chk_row(mk("rst_wait", 0, 0, 0, 1, 1, 0, 0, 0, 0, S_RST));
        tick();
        rst = 1'b0; pll_locked = 1'b1;
        wait_ready("rst_wait.reach_run", ok);
        rst = 1'b1;
        #1;
        chk_row(mk("rst_run", 0, 0, 0, 1, 1, 0, 0, 0, 0, S_RST));
        tick();
        rst = 1'b0;
        wait_ready("rst_run.reach_run", ok);

        // Restart coinciding with a lock loss in RUN still counts the loss.
        pll_locked = 1'b0;
        tick(); tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk_row(mk("restart_loss", 0, 0, 0, 1, 1, 0, 0, 0, 1, S_RST));

        // loss_cnt saturation.
        for (int i = 0; i < 256; i++) begin
            pll_locked = 1'b1;
            wait_ready($sformatf("sat%0d.run", i), ok);
            if (!ok) break;
            pll_locked = 1'b0;
            n = 0;
            while (core_rst !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            if (i == 0) chk("sat.loss_latency", n, 3);
            if (core_rst !== 1'b1) begin
                chk("sat.core_rst", core_rst, 1'b1);
                break;
            end
            if (i == 0)   chk("sat.loss_first", loss_cnt, 2);
            if (i == 100) chk("sat.loss_mid",   loss_cnt, 102);
            if (i == 253) chk("sat.loss_255",   loss_cnt, 255);
        end
        chk("sat.loss_hold", loss_cnt, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
